if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline. It is the producer side of the IF->ID interface.
- Generates PCs and fetches words from instruction memory over a req/ack handshake, buffering them in a 2-entry prefetch queue.
- Presents the queue head to ID as if_inst/if_pc4/IF_ins_type/IF_ins_number.
- Obeys ID's load-stall (hold) and branch/jump redirect (flush, refetch from new_pc).

---
 rtl/if_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: generates PCs, fetches over a req/ack handshake
// into a 2-entry prefetch queue, and presents the queue head to ID.
// Handles ID load stalls (hold) and branch/jump redirects (flush + refetch).
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic [3:0]  IF_ins_type,
  output logic [3:0]  IF_ins_number
);

  // RUN: normal fetching. DRAIN: a redirect arrived while a request was
  // outstanding; finish that handshake and throw the word away.
  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [3:0]  tag_q, tag_d;
  logic [1:0]  count_q, count_d;

  // Queue storage; entry 0 is always the head.
  logic [31:0] q_inst_q [0:1];
  logic [31:0] q_pc4_q  [0:1];
  logic [3:0]  q_tag_q  [0:1];
  logic [31:0] q_inst_d [0:1];
  logic [31:0] q_pc4_d  [0:1];
  logic [3:0]  q_tag_d  [0:1];

  logic        req_raw;
  logic [31:0] addr_raw;
  logic        push;
  logic        pop;
  logic        valid;
  logic [1:0]  wr_sel;

  // Instruction class from the opcode field.
  function automatic logic [3:0] ins_class(input logic [31:0] inst);
    logic [5:0] op;
    op = inst[31:26];
    if (inst == 32'd0)
      return 4'd0;
    case (op)
      6'b000000:            return 4'd1;
      6'b100011:            return 4'd3;
      6'b101011:            return 4'd4;
      6'b000100, 6'b000101: return 4'd5;
      6'b000010, 6'b000011: return 4'd6;
      default:              return 4'd2;
    endcase
  endfunction

  // Request/address generation; reset forces the request low immediately
  // so an in-flight ack is ignored.
  always_comb begin
    req_raw  = (state_q == S_DRAIN) ? 1'b1 : (count_q < 2'(QDEPTH));
    addr_raw = (state_q == S_DRAIN) ? drain_addr_q : fetch_pc_q;
    imem_req  = req_raw & ~rst;
    imem_addr = rst ? 32'd0 : addr_raw;
  end

  // Head-of-queue presentation to ID; zeros when empty.
  always_comb begin
    valid         = (count_q != 2'd0);
    if_valid      = valid;
    if_inst       = valid ? q_inst_q[0] : 32'd0;
    if_pc4        = valid ? q_pc4_q[0]  : 32'd0;
    IF_ins_number = valid ? q_tag_q[0]  : 4'd0;
    IF_ins_type   = ins_class(if_inst);
  end

  // Next-state: redirect beats everything, then drain completion, then
  // normal push/pop of the prefetch queue.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    tag_d        = tag_q;
    count_d      = count_q;
    for (int i = 0; i < 2; i++) begin
      q_inst_d[i] = q_inst_q[i];
      q_pc4_d[i]  = q_pc4_q[i];
      q_tag_d[i]  = q_tag_q[i];
    end
    push   = (state_q == S_RUN) & req_raw & imem_ack & ~branch;
    pop    = valid & ~stall & ~branch;
    wr_sel = count_q - {1'b0, pop};

    if (branch) begin
      count_d    = 2'd0;
      fetch_pc_d = new_pc;
      if (req_raw && !imem_ack) begin
        // Keep the outstanding address stable until the memory acks it.
        state_d = S_DRAIN;
        if (state_q == S_RUN)
          drain_addr_d = fetch_pc_q;
      end else begin
        state_d = S_RUN;
      end
    end else if (state_q == S_DRAIN) begin
      if (imem_ack)
        state_d = S_RUN;
    end else begin
      if (pop) begin
        q_inst_d[0] = q_inst_q[1];
        q_pc4_d[0]  = q_pc4_q[1];
        q_tag_d[0]  = q_tag_q[1];
      end
      if (push) begin
        // New word goes behind whatever survives this edge's pop.
        if (wr_sel[0]) begin
          q_inst_d[1] = imem_rdata;
          q_pc4_d[1]  = fetch_pc_q + 32'd4;
          q_tag_d[1]  = tag_q;
        end else begin
          q_inst_d[0] = imem_rdata;
          q_pc4_d[0]  = fetch_pc_q + 32'd4;
          q_tag_d[0]  = tag_q;
        end
        tag_d      = tag_q + 4'd1;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RUN;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
      tag_q        <= 4'd0;
      count_q      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_inst_q[i] <= 32'd0;
        q_pc4_q[i]  <= 32'd0;
        q_tag_q[i]  <= 4'd0;
      end
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      tag_q        <= tag_d;
      count_q      <= count_d;
      for (int i = 0; i < 2; i++) begin
        q_inst_q[i] <= q_inst_d[i];
        q_pc4_q[i]  <= q_pc4_d[i];
        q_tag_q[i]  <= q_tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, stall, redirect while full,
// redirect during a delayed handshake, mid-request reset, opcode classes.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch;
  logic [31:0] new_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic [3:0]  IF_ins_type;
  logic [3:0]  IF_ins_number;

  int checks = 0;
  int errors = 0;

  logic [31:0] dec_words [0:5];
  logic [3:0]  dec_types [0:5];

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch        (branch),
    .new_pc        (new_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_inst       (if_inst),
    .if_pc4        (if_pc4),
    .if_valid      (if_valid),
    .IF_ins_type   (IF_ins_type),
    .IF_ins_number (IF_ins_number)
  );

  always #5 clk = ~clk;

  // Memory model: a small table at 0x300..0x317, elsewhere 0x2000_0000 + word index.
  always_comb begin
    if (imem_addr >= 32'h300 && imem_addr < 32'h318)
      imem_rdata = dec_words[int'((imem_addr - 32'h300) >> 2)];
    else
      imem_rdata = 32'h2000_0000 + (imem_addr >> 2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_entry(input string tag, input logic [31:0] inst,
                           input logic [31:0] pc4, input logic [3:0] num);
    chk({tag, "_valid"}, 32'(if_valid), 32'd1);
    chk({tag, "_inst"}, if_inst, inst);
    chk({tag, "_pc4"}, if_pc4, pc4);
    chk({tag, "_num"}, 32'(IF_ins_number), 32'(num));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_inst"}, if_inst, 32'd0);
    chk({tag, "_pc4"}, if_pc4, 32'd0);
  endtask

  initial begin
    dec_words[0] = 32'h0000_0000; dec_types[0] = 4'd0;
    dec_words[1] = 32'h8C01_0004; dec_types[1] = 4'd3;
    dec_words[2] = 32'hAC01_0004; dec_types[2] = 4'd4;
    dec_words[3] = 32'h1022_0003; dec_types[3] = 4'd5;
    dec_words[4] = 32'h0800_0010; dec_types[4] = 4'd6;
    dec_words[5] = 32'h0022_1820; dec_types[5] = 4'd1;

    rst = 1'b1; stall = 1'b0; branch = 1'b0; new_pc = 32'd0; imem_ack = 1'b1;

    // Reset state.
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk_empty("rst");
    #3 rst = 1'b0;
    #1;
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'd0);
    chk("rel_valid", 32'(if_valid), 32'd0);

    // Streaming at one instruction per cycle, tag wraps after 15.
    for (int k = 0; k <= 16; k++) begin
      tick();
      chk_entry($sformatf("stream%0d", k), 32'h2000_0000 + 32'(k),
                32'(4 * (k + 1)), 4'(k % 16));
      chk($sformatf("stream%0d_type", k), 32'(IF_ins_type), 32'd2);
      chk($sformatf("stream%0d_addr", k), imem_addr, 32'(4 * (k + 1)));
    end

    // Stall three cycles: head held, request drops once full.
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk_entry($sformatf("stall%0d", s), 32'h2000_0010, 32'h44, 4'd0);
      chk($sformatf("stall%0d_req", s), 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    tick();
    chk_entry("unstall0", 32'h2000_0011, 32'h48, 4'd1);
    chk("unstall0_req", 32'(imem_req), 32'd1);
    chk("unstall0_addr", imem_addr, 32'h48);
    tick();
    chk_entry("unstall1", 32'h2000_0012, 32'h4C, 4'd2);

    // Fill the queue, then redirect to 0x100.
    stall = 1'b1;
    tick();
    chk("full_req", 32'(imem_req), 32'd0);
    branch = 1'b1; new_pc = 32'h100;
    tick();
    branch = 1'b0; stall = 1'b0;
    chk_empty("br100");
    chk("br100_addr", imem_addr, 32'h100);
    chk("br100_req", 32'(imem_req), 32'd1);
    tick();
    chk_entry("br100_first", 32'h2000_0040, 32'h104, 4'd4);

    // Redirect to 0x10 (same-edge ack discarded), then hold ack off.
    branch = 1'b1; new_pc = 32'h10;
    tick();
    branch = 1'b0; imem_ack = 1'b0;
    chk_empty("br10");
    chk("br10_addr", imem_addr, 32'h10);
    tick();
    chk("wait1_addr", imem_addr, 32'h10);
    chk("wait1_req", 32'(imem_req), 32'd1);
    branch = 1'b1; new_pc = 32'h200;
    tick();
    branch = 1'b0;
    chk("wait2_addr", imem_addr, 32'h10);
    chk("wait2_req", 32'(imem_req), 32'd1);
    chk("wait2_valid", 32'(if_valid), 32'd0);
    tick();
    chk("wait3_addr", imem_addr, 32'h10);
    chk("wait3_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    tick();
    chk_empty("drained");
    chk("drained_addr", imem_addr, 32'h200);
    chk("drained_req", 32'(imem_req), 32'd1);
    tick();
    chk_entry("br200_first", 32'h2000_0080, 32'h204, 4'd5);

    // Reset in the middle of an outstanding request.
    imem_ack = 1'b0;
    tick();
    chk("prerst_valid", 32'(if_valid), 32'd0);
    chk("prerst_addr", imem_addr, 32'h204);
    chk("prerst_req", 32'(imem_req), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_addr", imem_addr, 32'd0);
    chk_empty("midrst");
    imem_ack = 1'b1;
    tick();
    chk("rsthold_req", 32'(imem_req), 32'd0);
    chk("rsthold_valid", 32'(if_valid), 32'd0);
    #3 rst = 1'b0;
    #1;
    chk("rel2_req", 32'(imem_req), 32'd1);
    chk("rel2_addr", imem_addr, 32'd0);
    tick();
    chk_entry("rel2_first", 32'h2000_0000, 32'h4, 4'd0);

    // Opcode classes through the table at 0x300.
    branch = 1'b1; new_pc = 32'h300;
    tick();
    branch = 1'b0;
    chk("br300_valid", 32'(if_valid), 32'd0);
    chk("br300_addr", imem_addr, 32'h300);
    for (int d = 0; d < 6; d++) begin
      tick();
      chk_entry($sformatf("dec%0d", d), dec_words[d], 32'h304 + 32'(4 * d), 4'(d + 1));
      chk($sformatf("dec%0d_type", d), 32'(IF_ins_type), 32'(dec_types[d]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
